// File: rtl/delay_and_sum_mul_pkg.sv
// Shared mode constants, product-width helper and range limits for the DelayAndSum multiplier.
package delay_and_sum_mul_pkg;

  localparam logic MUL_UNSIGNED = 1'b0;
  localparam logic MUL_SIGNED   = 1'b1;

  // Limits are returned in a wide signed container so that they can be compared
  // directly against a sign- or zero-extended shifted product.
  localparam int unsigned LIM_W = 128;
  typedef logic signed [LIM_W-1:0] lim_t;

  function automatic int unsigned prod_width(input int unsigned w0, input int unsigned w1);
    return w0 + w1;
  endfunction

  function automatic lim_t umax(input int unsigned w);
    return (lim_t'(1) << w) - lim_t'(1);
  endfunction

  function automatic lim_t smax(input int unsigned w);
    return (lim_t'(1) << (w - 1)) - lim_t'(1);
  endfunction

  function automatic lim_t smin(input int unsigned w);
    return -(lim_t'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/delay_and_sum_mul_slice.sv
// One elastic pipeline register slice: valid bit plus payload, loads when empty or when downstream advances.
module delay_and_sum_mul_slice
  import delay_and_sum_mul_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         dn_adv,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  logic         load;
  logic         valid_d;
  logic [W-1:0] data_d;

  always_comb begin
    load    = !valid_q || dn_adv;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/delay_and_sum_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control, shift, range check and tag sideband.
// Define DELAY_AND_SUM_MUL_SAT_EN to clip overflowed results instead of wrapping them.
module delay_and_sum_mul_pipe
  import delay_and_sum_mul_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = 12,
  parameter int unsigned DIN1_WIDTH = 17,
  parameter int unsigned DOUT_WIDTH = 28,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_ovf
);

  localparam int unsigned P = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  // Operand slice stores {din0, din1}; product slices store the full product. Both are P bits.
  typedef struct packed {
    logic                 mode;
    logic [TAG_WIDTH-1:0] tag;
    logic [P-1:0]         data;
  } mid_t;

  typedef struct packed {
    logic                  ovf;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DOUT_WIDTH-1:0] dout;
  } last_t;

  function automatic mid_t mul_stage(input mid_t s);
    logic [DIN0_WIDTH-1:0] d0;
    logic [DIN1_WIDTH-1:0] d1;
    logic [P-1:0]          a;
    logic [P-1:0]          b;
    logic                  sx;
    mid_t                  o;
    {d0, d1} = s.data;
    sx       = (s.mode == MUL_SIGNED);
    a        = {{DIN1_WIDTH{sx & d0[DIN0_WIDTH-1]}}, d0};
    b        = {{DIN0_WIDTH{sx & d1[DIN1_WIDTH-1]}}, d1};
    o.mode   = s.mode;
    o.tag    = s.tag;
    o.data   = a * b;
    return o;
  endfunction

  function automatic last_t finish_stage(input mid_t s);
    logic [P-1:0] r;
    lim_t         rw;
    logic         ovf;
    last_t        o;
    if (s.mode == MUL_SIGNED) begin
      r   = $signed(s.data) >>> SHIFT;
      rw  = lim_t'($signed(r));
      ovf = (rw > smax(DOUT_WIDTH)) || (rw < smin(DOUT_WIDTH));
    end else begin
      r   = s.data >> SHIFT;
      rw  = lim_t'(r);
      ovf = (rw > umax(DOUT_WIDTH));
    end
`ifdef DELAY_AND_SUM_MUL_SAT_EN
    if (ovf) begin
      if (s.mode == MUL_SIGNED) begin
        rw = rw[LIM_W-1] ? smin(DOUT_WIDTH) : smax(DOUT_WIDTH);
      end else begin
        rw = umax(DOUT_WIDTH);
      end
    end
`endif
    o.ovf  = ovf;
    o.tag  = s.tag;
    o.dout = DOUT_WIDTH'(rw);
    return o;
  endfunction

  mid_t                 in_beat;
  mid_t                 mid_in [NUM_STAGE-1];
  mid_t                 mid_q  [NUM_STAGE-1];
  last_t                last_in;
  last_t                last_q;
  logic [NUM_STAGE-1:0] vld_q;
  logic [NUM_STAGE-1:0] up_vld;
  logic [NUM_STAGE:0]   adv;

  always_comb begin
    in_beat.mode = in_signed;
    in_beat.tag  = in_tag;
    in_beat.data = {din0, din1};
  end

  // Ready chain written closed-form from the valid flops: a slice can move when
  // out_ready is high or any slice at or after it is empty (bubbles collapse).
  always_comb begin
    adv            = '0;
    adv[NUM_STAGE] = out_ready;
    for (int unsigned k = NUM_STAGE; k > 0; k--) begin
      adv[k-1] = adv[k] | ~vld_q[k-1];
    end
  end

  assign up_vld = {vld_q[NUM_STAGE-2:0], in_valid};

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    if (k < NUM_STAGE - 1) begin : g_mid
      if (k == 0) begin : g_in
        assign mid_in[k] = in_beat;
      end else if (k == 1) begin : g_mul
        assign mid_in[k] = mul_stage(mid_q[0]);
      end else begin : g_pass
        assign mid_in[k] = mid_q[k-1];
      end
      delay_and_sum_mul_slice #(.W($bits(mid_t))) u_slice (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .up_valid (up_vld[k]),
        .up_data  (mid_in[k]),
        .dn_adv   (adv[k+1]),
        .valid_q  (vld_q[k]),
        .data_q   (mid_q[k])
      );
    end else begin : g_last
      if (k == 1) begin : g_mul_fin
        assign last_in = finish_stage(mul_stage(mid_q[0]));
      end else begin : g_fin
        assign last_in = finish_stage(mid_q[k-1]);
      end
      delay_and_sum_mul_slice #(.W($bits(last_t))) u_slice (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .up_valid (up_vld[k]),
        .up_data  (last_in),
        .dn_adv   (adv[k+1]),
        .valid_q  (vld_q[k]),
        .data_q   (last_q)
      );
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[NUM_STAGE-1];
  assign dout      = last_q.dout;
  assign out_tag   = last_q.tag;
  assign out_ovf   = last_q.ovf;

endmodule

// File: tb/tb_delay_and_sum_mul_pipe.sv
// Bench for delay_and_sum_mul_pipe: table vectors, backpressure, mid-stream reset and a random stream.
module tb_delay_and_sum_mul_pipe;

  localparam int D0 = 12;
  localparam int D1 = 17;
  localparam int DW = 28;
  localparam int NS = 3;
  localparam int TW = 4;
  localparam int SH_B = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic [D0-1:0] din0 = '0;
  logic [D1-1:0] din1 = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_ready = 1'b1;

  logic          in_ready_a, out_valid_a, out_ovf_a;
  logic [DW-1:0] dout_a;
  logic [TW-1:0] out_tag_a;
  logic          in_ready_b, out_valid_b, out_ovf_b;
  logic [DW-1:0] dout_b;
  logic [TW-1:0] out_tag_b;

  always #5 ap_clk = ~ap_clk;

  delay_and_sum_mul_pipe #(
    .DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(DW),
    .NUM_STAGE(NS), .SHIFT(0), .TAG_WIDTH(TW)
  ) u_dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_signed(in_signed),
    .din0(din0), .din1(din1), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .dout(dout_a), .out_tag(out_tag_a), .out_ovf(out_ovf_a)
  );

  delay_and_sum_mul_pipe #(
    .DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(DW),
    .NUM_STAGE(NS), .SHIFT(SH_B), .TAG_WIDTH(TW)
  ) u_dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_signed(in_signed),
    .din0(din0), .din1(din1), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .dout(dout_b), .out_tag(out_tag_b), .out_ovf(out_ovf_b)
  );

  typedef struct {
    bit            s;
    logic [D0-1:0] a;
    logic [D1-1:0] b;
    logic [TW-1:0] tag;
    bit            use_tab;
    logic [DW-1:0] d;
    bit            o;
  } vec_t;

  typedef struct {
    logic [DW-1:0] da;
    bit            oa;
    logic [DW-1:0] db;
    bit            ob;
    logic [TW-1:0] tag;
    int            stamp;
    bit            chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stalled_acc = 0;
  bit   rnd_done = 1'b0;
  vec_t tbl[9];

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: 64-bit integer arithmetic on extended operands.
  task automatic model(input bit s, input logic [D0-1:0] a, input logic [D1-1:0] b,
                       input int sh, output logic [DW-1:0] d, output bit o);
    longint av, bv, p, r, lim;
    av = s ? longint'($signed(a)) : longint'(a);
    bv = s ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    r  = p >>> sh;
    lim = longint'(1) << (DW - 1);
    if (s) o = (r > lim - 1) || (r < -lim);
    else   o = (r > (longint'(1) << DW) - 1);
    d = r[DW-1:0];
`ifdef DELAY_AND_SUM_MUL_SAT_EN
    if (o) d = s ? ((r < 0) ? 28'h8000000 : 28'h7FFFFFF) : 28'hFFFFFFF;
`endif
  endtask

  function automatic vec_t rnd_vec(input logic [TW-1:0] tag);
    vec_t v;
    v.s = 1'($urandom_range(0, 1));
    v.a = 12'($urandom);
    v.b = 17'($urandom);
    v.tag = tag;
    v.use_tab = 1'b0;
    v.d = '0;
    v.o = 1'b0;
    return v;
  endfunction

  task automatic send(input vec_t v, input bit chk_lat);
    exp_t          e;
    logic [DW-1:0] d;
    bit            o;
    @(negedge ap_clk);
    in_valid = 1'b1; in_signed = v.s; din0 = v.a; din1 = v.b; in_tag = v.tag;
    #1;
    for (int w = 0; w < 64 && !in_ready_a; w++) begin
      @(negedge ap_clk);
      #1;
    end
    if (!in_ready_a) begin
      chk("send_timeout", 64'(in_ready_a), 64'(1));
      in_valid = 1'b0;
      return;
    end
    if (!out_ready) stalled_acc++;
    if (v.use_tab) begin
      e.da = v.d; e.oa = v.o;
    end else begin
      model(v.s, v.a, v.b, 0, d, o);
      e.da = d; e.oa = o;
    end
    model(v.s, v.a, v.b, SH_B, d, o);
    e.db = d; e.ob = o;
    e.tag = v.tag; e.stamp = cyc; e.chk_lat = chk_lat;
    sb.push_back(e);
    @(posedge ap_clk);
  endtask

  task automatic idle();
    @(negedge ap_clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 300 && sb.size() != 0; w++) @(negedge ap_clk);
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  // Output monitor: every visible beat (stalled or transferring) must match the queue head.
  always @(negedge ap_clk) begin
    exp_t e;
    #2;
    if (out_valid_a) begin
      if (sb.size() == 0) begin
        chk("spurious_beat", 64'(sb.size() == 0), 64'(0));
      end else begin
        e = sb[0];
        chk("dout_a", 64'(dout_a), 64'(e.da));
        chk("ovf_a", 64'(out_ovf_a), 64'(e.oa));
        chk("tag_a", 64'(out_tag_a), 64'(e.tag));
        chk("valid_b", 64'(out_valid_b), 64'(1));
        chk("dout_b", 64'(dout_b), 64'(e.db));
        chk("ovf_b", 64'(out_ovf_b), 64'(e.ob));
        chk("tag_b", 64'(out_tag_b), 64'(e.tag));
        if (out_ready) begin
          if (e.chk_lat) chk("latency", 64'(cyc - e.stamp), 64'(NS));
          void'(sb.pop_front());
        end
      end
    end else if (out_valid_b) begin
      chk("valid_b_alone", 64'(out_valid_b), 64'(0));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 12'd3,   17'd5,       4'hA, 1'b1, 28'd15,       1'b0};
`ifdef DELAY_AND_SUM_MUL_SAT_EN
    tbl[1] = '{1'b0, 12'hFFF, 17'h1FFFF,   4'h1, 1'b1, 28'hFFFFFFF,  1'b1};
    tbl[2] = '{1'b1, 12'h800, 17'h10000,   4'h2, 1'b1, 28'h7FFFFFF,  1'b1};
`else
    tbl[1] = '{1'b0, 12'hFFF, 17'h1FFFF,   4'h1, 1'b1, 28'hFFDF001,  1'b1};
    tbl[2] = '{1'b1, 12'h800, 17'h10000,   4'h2, 1'b1, 28'h8000000,  1'b1};
`endif
    tbl[3] = '{1'b1, 12'hFFD, 17'd5,       4'h3, 1'b1, 28'hFFFFFF1,  1'b0};
    tbl[4] = '{1'b1, 12'hFFF, 17'h1FFFF,   4'h4, 1'b1, 28'd1,        1'b0};
    tbl[5] = '{1'b0, 12'hFFF, 17'd1,       4'h5, 1'b1, 28'hFFF,      1'b0};
    tbl[6] = '{1'b1, 12'h7FF, 17'h0FFFF,   4'h6, 1'b1, 28'h7FEF801,  1'b0};
    tbl[7] = '{1'b1, 12'h800, 17'h0FFFF,   4'h7, 1'b1, 28'h8000800,  1'b0};
    tbl[8] = '{1'b0, 12'h000, 17'h1FFFF,   4'hF, 1'b1, 28'd0,        1'b0};

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid_a), 64'(0));
    chk("rst_in_ready_a", 64'(in_ready_a), 64'(1));
    chk("rst_in_ready_b", 64'(in_ready_b), 64'(1));
    chk("rst_dout", 64'(dout_a), 64'(0));
    chk("rst_tag", 64'(out_tag_a), 64'(0));
    chk("rst_ovf", 64'(out_ovf_a), 64'(0));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready_a), 64'(1));

    // Table vectors, back-to-back, no backpressure
    for (int i = 0; i < 9; i++) send(tbl[i], 1'b1);
    idle();
    drain();

    // Backpressure: 8 beats while out_ready is low for 6 cycles
    @(negedge ap_clk);
    out_ready = 1'b0;
    stalled_acc = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd_vec(4'(i)), 1'b0);
        idle();
      end
      begin
        repeat (5) @(negedge ap_clk);
        #1;
        chk("bp_in_ready_low", 64'(in_ready_a), 64'(0));
        @(negedge ap_clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_accepted_while_stalled", 64'(stalled_acc), 64'(NS));

    // Reset with three beats in flight
    @(negedge ap_clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_vec(4'(i + 8)), 1'b0);
    #1;
    chk("inflight_valid", 64'(out_valid_a), 64'(1));
    #1;
    ap_rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_valid_drop", 64'(out_valid_a), 64'(0));
    chk("async_rst_in_ready", 64'(in_ready_a), 64'(1));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge ap_clk);
      #3;
      chk("no_stale_beat", 64'(out_valid_a), 64'(0));
    end
    send(tbl[0], 1'b1);
    idle();
    drain();

    // Random stream with random backpressure
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send(rnd_vec(4'(i)), 1'b0);
          if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge ap_clk);
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    @(negedge ap_clk);
    out_ready = 1'b1;
    drain();

    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_and_sum_mul_pipe.md
Name: delay_and_sum_mul_pipe

Overview:
- Parametrised, pipelined multiplier with valid/ready handshake; successor to the fixed-width combinational multiplier cores.
- Adds per-transaction signed/unsigned mode, a configurable arithmetic right shift, backpressure with no loss of data, and a sideband tag for channel id.
- Sits between the delay-line sample fetch and the weighted summation tree in the DelayAndSum datapath.

Parameters:
- DIN0_WIDTH, 12, width of operand 0.
- DIN1_WIDTH, 17, width of operand 1.
- DOUT_WIDTH, 28, result width; must be >= 2.
- NUM_STAGE, 3, pipeline depth in cycles; legal range 2..8.
- SHIFT, 0, right shift applied to the full product; legal range 0..DIN0_WIDTH+DIN1_WIDTH-1.
- TAG_WIDTH, 4, width of the sideband tag, passed through unchanged.

Ports:
- ap_clk  in  1  clock; all logic is rising-edge triggered.
- ap_rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_signed  in  1  1 = both operands are two's complement; 0 = both unsigned.
- din0  in  DIN0_WIDTH  operand 0.
- din1  in  DIN1_WIDTH  operand 1.
- in_tag  in  TAG_WIDTH  channel id.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- dout  out  DOUT_WIDTH  result.
- out_tag  out  TAG_WIDTH  tag of the beat on dout.
- out_ovf  out  1  result overflowed DOUT range; wrapped, or clipped when saturation is compiled in.

Behaviour:
- Transfer rules
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
- Pipeline structure
  - The pipeline has NUM_STAGE register slices. Each slice holds: valid, mode, tag, and data.
  - Slice 1 captures the operands and mode.
  - The multiply is evaluated combinationally from slice 1 into slice 2.
  - The shift and the range check are evaluated combinationally into slice NUM_STAGE. dout, out_tag and out_ovf come directly from the slice NUM_STAGE registers.
- Stall and bubble handling
  - Slice k advances when slice k+1 is empty or slice k+1 advances.
  - The last slice advances when out_ready is high.
  - in_ready = !valid[1] || slice 1 advances. in_ready is combinational from out_ready through the valid chain; this path is accepted.
  - Bubbles collapse, so up to NUM_STAGE beats are buffered while out_ready is low.
- Latency and throughput
  - Latency is exactly NUM_STAGE cycles from the input transfer to out_valid, when there is no backpressure.
  - Throughput is 1 beat per cycle while out_ready is held high.
- Arithmetic
  - Unsigned mode: both operands are zero-extended.
  - Signed mode: both operands are sign-extended.
  - The full product is P = DIN0_WIDTH+DIN1_WIDTH bits wide.
  - Then r = P >> SHIFT; the shift is arithmetic in signed mode and logical in unsigned mode.
  - Range check on r:
    - unsigned mode: r > 2^DOUT_WIDTH-1;
    - signed mode: r outside [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
    - On overflow, out_ovf = 1.
  - Default output, no macro: dout = the low DOUT_WIDTH bits of r (wrap).
- Ordering: output order equals input order; the tag and mode travel with the data.
- Reset
  - On reset, all valid bits, dout, out_tag and out_ovf go to 0, and out_valid is 0.
  - in_ready is 1 during reset and on the first cycle after reset.
  - Reset asserted mid-operation discards every in-flight beat; no partial result is emitted.
- Output stability: while out_valid && !out_ready, dout, out_tag and out_ovf hold stable.

Optional Feature:
- Macro: DELAY_AND_SUM_MUL_SAT_EN.
- When defined, overflowed results are clipped:
  - unsigned mode: 2^DOUT_WIDTH-1;
  - signed mode: the positive or negative limit, according to the sign of r.
  - out_ovf is still asserted.
- When undefined, results wrap as described in Behaviour. out_ovf is still asserted; the port is present in both builds.

Decomposition:
- Package delay_and_sum_mul_pkg contains:
  - the mode constants MUL_UNSIGNED = 0 and MUL_SIGNED = 1;
  - a function that computes the product width;
  - signed and unsigned min/max limit functions parametrised by width, used by the range check and the saturation logic.
- Sub-module delay_and_sum_mul_slice: one pipeline slice with a parametrised payload width, its valid bit, the advance logic, and an asynchronous active-low reset. It is instantiated NUM_STAGE times via a generate loop.

Test Plan:
- Latency, defaults, in_signed=0, din0=3, din1=5, tag=0xA, out_ready=1 → out_valid exactly 3 cycles after the transfer; dout=15; out_tag=0xA; out_ovf=0.
- Unsigned overflow, din0=0xFFF, din1=0x1FFFF → full product 0x1FFDF001; dout=0xFFDF001 with out_ovf=1 in the wrap build; dout=0xFFFFFFF with out_ovf=1 in the SAT build.
- Signed overflow, in_signed=1, din0=0x800 (-2048), din1=0x10000 (-65536) → product +0x8000000; wrap build dout=0x8000000, SAT build dout=0x7FFFFFF; out_ovf=1 in both.
- Shift, SHIFT=4, in_signed=1, din0=0xFFD (-3), din1=5 → -15>>4 = -1; dout=0xFFFFFFF; out_ovf=0.
- Backpressure, 8 back-to-back beats with tags 0..7 while out_ready is held low for 6 cycles → at most 3 beats accepted before in_ready=0; dout stable while stalled; all 8 results emerge in tag order; no duplicates.
- Reset mid-stream: assert ap_rst_n=0 asynchronously with 3 beats in flight → out_valid drops immediately; no stale beat appears after release; the next beat has correct 3-cycle latency.
